ram_dp_param: RTL and testbench
===============================

# ram_dp_param

Parametrised simple dual-port RAM; next generation of `ram_general`. One write port and one read port share a single clock. New relative to its predecessor:
- configurable data width, depth and read latency
- read-enable with a `dout_valid` strobe
- hardware memory-initialisation sequencer after reset
- optional read-during-write forwarding

It is the storage primitive used behind the team's buffer and frame-store blocks.

## Interface
Parameters:
- `DATA_W`, 8: data word width in bits.
- `ADDR_W`, 8: address width; depth = 2^ADDR_W words.
- `RD_LAT`, 1: read latency in cycles; legal values 1 or 2.
- `INIT_VAL`, 0: value written to every location by the init sequencer; truncated to DATA_W.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wrt_sig`  in  1  write enable; writes `din_ram` to `addr_w` at the clock edge.
- `addr_w`  in  ADDR_W  write address.
- `din_ram`  in  DATA_W  write data.
- `rd_en`  in  1  read request for `addr_r`.
- `addr_r`  in  ADDR_W  read address.
- `dout_ram`  out  DATA_W  read data, qualified by `dout_valid`.
- `dout_valid`  out  1  one-cycle strobe per accepted read.
- `init_busy`  out  1  high while the init sequencer owns the array.

## Operation
- FSM states: INIT and READY. `rst`=1 forces INIT with the internal init counter = 0, regardless of current state.
- INIT state:
  - Each cycle writes INIT_VAL to location `init_cnt`, then increments `init_cnt`.
  - After location 2^ADDR_W−1 is written, the FSM moves to READY on the next edge. INIT therefore lasts exactly 2^ADDR_W cycles after reset deasserts.
  - `wrt_sig` and `rd_en` are ignored: no write occurs and no `dout_valid` is produced. Requests are dropped, not queued.
- READY state:
  - `wrt_sig`=1 writes `din_ram` to `addr_w`.
  - `rd_en`=1 captures `addr_r`. Data appears on `dout_ram` with `dout_valid`=1 exactly RD_LAT cycles later.
  - Reads are fully pipelined: one read accepted per cycle, back-to-back allowed.
- `dout_ram` holds its last valid value when `dout_valid`=0. It is not cleared between reads.
- Same-cycle `wrt_sig` and `rd_en` to different addresses are independent.
- Same-cycle `wrt_sig` and `rd_en` to the same address are governed by the Configuration section.
- Addresses span the full 2^ADDR_W range, so no out-of-range case exists.
- A reset in the middle of a read pipeline discards all in-flight reads; their `dout_valid` never fires.
- Array contents are not reset directly; they are overwritten by the INIT state.

## Timing
- Reset values: `dout_ram`=0, `dout_valid`=0, `init_busy`=1. Internal read pipeline valid bits are all 0.
- `init_busy`:
  - Stays 1 from the first edge with `rst`=1 through the last INIT write cycle.
  - Is 0 starting the first READY cycle.
- RD_LAT=1: `rd_en` sampled at edge N → `dout_ram`/`dout_valid` valid after edge N+1.
- RD_LAT=2: same, valid after edge N+2. The extra stage is an output register.
- Write is committed at the edge where `wrt_sig`=1. A read issued at a later edge returns the new data.

## Configuration
- Macro: `RAM_DP_BYPASS_EN`.
- Defined: a same-cycle write and read to the same address returns the newly written `din_ram` (write-first), using forwarding logic on the captured read address.
- Undefined: the same case returns the previous contents (read-first). No forwarding logic is generated.
- The macro affects only the same-address, same-cycle case; all other behaviour is identical.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4, RD_LAT=1, INIT_VAL=8'hA5 unless stated.
- Init check: assert `rst` 2 cycles, release → `init_busy`=1 for exactly 16 cycles; then reads of addresses 0..15 all return 8'hA5 with one `dout_valid` per read.
- Access during init: `wrt_sig`=1, addr 3, data 8'h11, and `rd_en`=1 in the 5th init cycle → no `dout_valid`; after READY, a read of addr 3 returns 8'hA5.
- Pipelined write/read: write 8'h00..8'h0F to addr 0..15, then `rd_en` on 16 consecutive cycles → `dout_ram` streams 8'h00..8'h0F, `dout_valid` high 16 cycles, 1-cycle latency. Repeat with RD_LAT=2 → 2-cycle latency, same stream.
- Collision: addr 7 holds 8'h33; same cycle write 8'hC4 to addr 7 and read addr 7 → returns 8'hC4 with `RAM_DP_BYPASS_EN` defined, 8'h33 without; the following read returns 8'hC4 in both builds.
- Reset mid-operation: issue a read with RD_LAT=2 and assert `rst` the next cycle → no `dout_valid`, `dout_ram`=0, a full 16-cycle INIT reruns, and all locations read back 8'hA5.

Source files
------------

// File: rtl/ram_dp_param.sv
// Parametrised simple dual-port RAM with a post-reset init sequencer and a 1- or 2-cycle read pipeline.
// Optional macro RAM_DP_BYPASS_EN selects write-first behaviour for same-cycle, same-address write/read.
module ram_dp_param #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 8,
  parameter int              RD_LAT   = 1,
  parameter logic [63:0]     INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_sig,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] din_ram,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] dout_ram,
  output logic              dout_valid,
  output logic              init_busy
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] INIT_WORD = INIT_VAL[DATA_W-1:0];

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                rd_accept;

  logic                rd_v1;
  logic [DATA_W-1:0]   rd_data1;
  logic [DATA_W-1:0]   rd_word1;
  logic                v2;
  logic [DATA_W-1:0]   data2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT)
        init_cnt <= init_cnt + 1'b1;
    end
  end

  // The init sequencer owns the write port and blocks reads until every word is written.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = addr_w;
    mem_wdata = din_ram;
    rd_accept = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = init_cnt;
        mem_wdata = INIT_WORD;
        if (init_cnt == {ADDR_W{1'b1}})
          state_d = ST_READY;
      end
      ST_READY: begin
        mem_we    = wrt_sig;
        rd_accept = rd_en;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Array read happens on the capture edge, so the old word is seen on a collision (read-first).
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem[mem_waddr] <= mem_wdata;
    if (rd_accept)
      rd_data1 <= mem[addr_r];
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_v1 <= 1'b0;
    else
      rd_v1 <= rd_accept;
  end

`ifdef RAM_DP_BYPASS_EN
  logic [ADDR_W-1:0] rd_addr1;
  logic              wr_v1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_v1 <= 1'b0;
    end else begin
      wr_v1 <= (state_q == ST_READY) && wrt_sig;
    end
    rd_addr1 <= addr_r;
    wr_addr1 <= addr_w;
    wr_data1 <= din_ram;
  end

  // Forward the word written on the same edge the read address was captured.
  always_comb begin
    rd_word1 = rd_data1;
    if (wr_v1 && (wr_addr1 == rd_addr1))
      rd_word1 = wr_data1;
  end
`else
  always_comb begin
    rd_word1 = rd_data1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      data2 <= '0;
    end else begin
      v2 <= rd_v1;
      if (rd_v1)
        data2 <= rd_word1;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign dout_ram   = data2;
      assign dout_valid = v2;
    end else begin : g_lat2
      logic              v3;
      logic [DATA_W-1:0] data3;

      always_ff @(posedge clk) begin
        if (rst) begin
          v3    <= 1'b0;
          data3 <= '0;
        end else begin
          v3 <= v2;
          if (v2)
            data3 <= data2;
        end
      end

      assign dout_ram   = data3;
      assign dout_valid = v3;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_param.sv
// Randomised + directed bench for ram_dp_param; drives an RD_LAT=1 and an RD_LAT=2 instance in lockstep
// against a word-array reference model with per-latency read queues.
module tb_ram_dp_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam logic [7:0] INITV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst, wrt_sig, rd_en;
  logic [AW-1:0] addr_w, addr_r;
  logic [DW-1:0] din_ram;
  logic [DW-1:0] dout1, dout2;
  logic          dv1, dv2, busy1, busy2;

  always #5 clk = ~clk;

  ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .INIT_VAL(64'hA5)) u_lat1 (
    .clk(clk), .rst(rst), .wrt_sig(wrt_sig), .addr_w(addr_w), .din_ram(din_ram),
    .rd_en(rd_en), .addr_r(addr_r), .dout_ram(dout1), .dout_valid(dv1), .init_busy(busy1)
  );

  ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .INIT_VAL(64'hA5)) u_lat2 (
    .clk(clk), .rst(rst), .wrt_sig(wrt_sig), .addr_w(addr_w), .din_ram(din_ram),
    .rd_en(rd_en), .addr_r(addr_r), .dout_ram(dout2), .dout_valid(dv2), .init_busy(busy2)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_t;

  logic [7:0] ref_mem [DEPTH];
  rd_t        q1[$];
  rd_t        q2[$];
  int         busy_left;
  int         cyc = 0;
  logic [7:0] exp_d1, exp_d2;
  logic       exp_v1, exp_v2;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the reference model, compare both instances.
  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    rd_t e;
    rst = r; wrt_sig = we; addr_w = wa; din_ram = wd; rd_en = re; addr_r = ra;
    @(posedge clk);
    cyc++;
    if (r) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = INITV;
      q1.delete();
      q2.delete();
      exp_v1 = 1'b0; exp_v2 = 1'b0;
      exp_d1 = '0;   exp_d2 = '0;
    end else begin
      exp_v1 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        exp_v1 = 1'b1; exp_d1 = q1[0].data; void'(q1.pop_front());
      end
      exp_v2 = 1'b0;
      if (q2.size() > 0 && q2[0].due == cyc) begin
        exp_v2 = 1'b1; exp_d2 = q2[0].data; void'(q2.pop_front());
      end
      if (busy_left > 0) begin
        busy_left--;
      end else begin
        if (re) begin
          e.data = ref_mem[ra];
`ifdef RAM_DP_BYPASS_EN
          if (we && wa == ra) e.data = wd;
`endif
          e.due = cyc + 1; q1.push_back(e);
          e.due = cyc + 2; q2.push_back(e);
        end
        if (we) ref_mem[wa] = wd;
      end
    end
    #1;
    checkOutput("busy_lat1",  {31'd0, busy1}, {31'd0, busy_left > 0});
    checkOutput("busy_lat2",  {31'd0, busy2}, {31'd0, busy_left > 0});
    checkOutput("valid_lat1", {31'd0, dv1},   {31'd0, exp_v1});
    checkOutput("valid_lat2", {31'd0, dv2},   {31'd0, exp_v2});
    checkOutput("dout_lat1",  {24'd0, dout1}, {24'd0, exp_d1});
    checkOutput("dout_lat2",  {24'd0, dout2}, {24'd0, exp_d2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic readAll();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(i));
    idle(3);
  endtask

  initial begin
    rst = 1'b1; wrt_sig = 1'b0; rd_en = 1'b0; addr_w = '0; addr_r = '0; din_ram = '0;

    // Reset, then init with an ignored write+read in the 5th init cycle.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 4) applyStimulus(1'b0, 1'b1, 4'd3, 8'h11, 1'b1, 4'd3);
      else        idle(1);
    end
    idle(1);
    readAll();

    // Pipelined write then back-to-back reads.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, AW'(i), DW'(i), 1'b0, '0);
    readAll();

    // Same-cycle collision on address 7.
    applyStimulus(1'b0, 1'b1, 4'd7, 8'h33, 1'b0, '0);
    idle(1);
    applyStimulus(1'b0, 1'b1, 4'd7, 8'hC4, 1'b1, 4'd7);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd7);
    idle(3);

    // Reset while a read is in flight.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd5);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(DEPTH + 2);
    readAll();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 149) == 0), 1'($urandom), AW'($urandom), DW'($urandom),
                    1'($urandom), AW'($urandom));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
